// File: rtl/fft_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_dac_pkg
// Purpose  : Shared states, default parameters and counter-width helpers for
//            the FFT DAC serial transmitter.
// Revision : 1.0  initial release
// ============================================================================
package fft_dac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } dac_state_t;

    localparam int DAC_DATA_W  = 16;
    localparam int DAC_CLK_DIV = 4;
    localparam int DAC_CS_GAP  = 8;

    function automatic int div_cnt_w(input int clk_div);
        return $clog2(clk_div) + 1;
    endfunction

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    function automatic int gap_cnt_w(input int cs_gap);
        return $clog2(cs_gap) + 1;
    endfunction

    localparam int DAC_DIV_CNT_W = div_cnt_w(DAC_CLK_DIV);
    localparam int DAC_BIT_CNT_W = bit_cnt_w(DAC_DATA_W);
    localparam int DAC_GAP_CNT_W = gap_cnt_w(DAC_CS_GAP);

endpackage
`default_nettype wire

// File: rtl/fft_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_dac_tx_if
// Purpose  : Sample handshake plus DAC pin bundle for fft_dac_tx.
// Revision : 1.0  initial release
// ============================================================================
interface fft_dac_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] iDATA;
    logic              iVALID;
    logic              oREADY;
    logic              oDONE;
    logic              oDAC_DATA;
    logic              oDAC_CS;
    logic              oDAC_CLK;

    modport master (
        output iDATA, iVALID,
        input  oREADY, oDONE, oDAC_DATA, oDAC_CS, oDAC_CLK
    );

    modport slave (
        input  iDATA, iVALID,
        output oREADY, oDONE, oDAC_DATA, oDAC_CS, oDAC_CLK
    );
endinterface
`default_nettype wire

// File: rtl/fft_dac_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : fft_dac_clkgen
// Purpose  : Half-period counter; strobes once every CLK_DIV enabled cycles.
// Revision : 1.0  initial release
// ============================================================================
module fft_dac_clkgen
    import fft_dac_pkg::*;
#(
    parameter int CLK_DIV = DAC_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_strobe
);
    localparam int                CNT_W      = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_strobe = i_en && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/fft_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : fft_dac_tx
// Purpose  : Serialises one parallel sample per handshake to the DAC, MSB
//            first, framed by an active-low chip select.
// Revision : 1.0  initial release
// ============================================================================
module fft_dac_tx
    import fft_dac_pkg::*;
#(
    parameter int DATA_W  = DAC_DATA_W,
    parameter int CLK_DIV = DAC_CLK_DIV,
    parameter int CS_GAP  = DAC_CS_GAP
) (
    input  logic        iCLK,
    input  logic        iRESET,
    fft_dac_tx_if.slave dac
);
    localparam int               BIT_W      = bit_cnt_w(DATA_W);
    localparam int               GAP_W      = gap_cnt_w(CS_GAP);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_W);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(CS_GAP - 1);

    dac_state_t        r_state,   w_state_nxt;
    logic [DATA_W-1:0] r_shreg,   w_shreg_nxt;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
    logic              r_ready,   w_ready_nxt;
    logic              r_done,    w_done_nxt;
    logic              r_cs,      w_cs_nxt;
    logic              r_sclk,    w_sclk_nxt;

    logic w_accept;
    logic w_div_en;
    logic w_strobe;

    assign w_accept = dac.iVALID && r_ready;
    assign w_div_en = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

    fft_dac_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (iCLK),
        .rst      (iRESET),
        .i_clear  (w_accept),
        .i_en     (w_div_en),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
            r_cs      <= w_cs_nxt;
            r_sclk    <= w_sclk_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_ready_nxt   = r_ready;
        w_done_nxt    = 1'b0;
        w_cs_nxt      = r_cs;
        w_sclk_nxt    = r_sclk;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = SETUP;
                    w_shreg_nxt   = dac.iDATA;
                    w_bit_cnt_nxt = '0;
                    w_ready_nxt   = 1'b0;
                    w_cs_nxt      = 1'b0;
                    w_sclk_nxt    = 1'b0;
                end
            end
            SETUP: begin
                if (w_strobe) begin
                    w_state_nxt   = SHIFT;
                    w_sclk_nxt    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                end
            end
            SHIFT: begin
                if (w_strobe) begin
                    if (r_sclk) begin
                        w_sclk_nxt = 1'b0;
                        // The LSB is not shifted away so it stays on the pin through HOLD.
                        if (r_bit_cnt != c_bit_last) begin
                            w_shreg_nxt = {r_shreg[DATA_W-2:0], 1'b0};
                        end
                    end else if (r_bit_cnt == c_bit_last) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_sclk_nxt    = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (w_strobe) begin
                    w_state_nxt   = GAP;
                    w_cs_nxt      = 1'b1;
                    w_shreg_nxt   = '0;
                    w_gap_cnt_nxt = '0;
                    w_done_nxt    = (c_gap_last == '0);
                end
            end
            GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = IDLE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    w_done_nxt    = ((r_gap_cnt + GAP_W'(1)) == c_gap_last);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
                w_cs_nxt    = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_shreg_nxt = '0;
            end
        endcase
    end

    assign dac.oREADY    = r_ready;
    assign dac.oDONE     = r_done;
    assign dac.oDAC_CS   = r_cs;
    assign dac.oDAC_CLK  = r_sclk;
    assign dac.oDAC_DATA = r_shreg[DATA_W-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_dac_tx
// Purpose  : Scoreboard bench for fft_dac_tx with default and fastest settings.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_dac_tx;
    localparam int W  = 16;
    localparam int D0 = 4;
    localparam int G0 = 8;
    localparam int D1 = 1;
    localparam int G1 = 1;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_dac_tx_if #(.DATA_W(W)) if0 ();
    fft_dac_tx_if #(.DATA_W(W)) if1 ();

    fft_dac_tx #(.DATA_W(W), .CLK_DIV(D0), .CS_GAP(G0)) u_dut0 (
        .iCLK   (clk),
        .iRESET (rst0),
        .dac    (if0)
    );

    fft_dac_tx #(.DATA_W(W), .CLK_DIV(D1), .CS_GAP(G1)) u_dut1 (
        .iCLK   (clk),
        .iRESET (rst1),
        .dac    (if1)
    );

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    int           acc[2];
    int           nedge[2];
    int           last_rise[2];
    int           last_chg[2];
    bit           active[2]    = '{1'b0, 1'b0};
    bit           done_seen[2];
    bit           have_acc[2]  = '{1'b0, 1'b0};
    logic [W-1:0] cap[2];
    logic         prev_clk[2]   = '{1'b0, 1'b0};
    logic         prev_data[2]  = '{1'b0, 1'b0};
    logic         prev_ready[2] = '{1'b0, 1'b0};

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_exp(input int id, output logic [W-1:0] w, output bit ok);
        ok = 1'b1;
        w  = '0;
        if (id == 0) begin
            if (q0.size() > 0) w = q0.pop_front(); else ok = 1'b0;
        end else begin
            if (q1.size() > 0) w = q1.pop_front(); else ok = 1'b0;
        end
    endtask

    // Frame model: t counts cycles from the accept edge, outputs follow the
    // published cycle formulas for serial clock, chip select and handshake.
    task automatic mon(input int id, input int d, input int gap, input bit exact,
                       input logic rst_s, input logic valid_s, input logic cs,
                       input logic dclk, input logic dat, input logic rdy, input logic dn);
        int           f;
        int           t;
        logic [W-1:0] exp_w;
        bit           ok;
        f = 1 + (2 * W + 2) * d;
        if (rst_s) begin
            if (active[id]) pop_exp(id, exp_w, ok);
            active[id] = 1'b0;
            check({cs, dclk, dat, rdy, dn} == 5'b10010, "reset_outputs",
                  {cs, dclk, dat, rdy, dn}, 5'b10010);
        end else begin
            if (valid_s && prev_ready[id]) begin
                if (exact && have_acc[id])
                    check(cyc - acc[id] == f + gap, "frame_spacing", cyc - acc[id], f + gap);
                have_acc[id]  = 1'b1;
                acc[id]       = cyc;
                active[id]    = 1'b1;
                cap[id]       = '0;
                nedge[id]     = 0;
                last_rise[id] = 0;
                last_chg[id]  = 1;
                done_seen[id] = 1'b0;
            end
            if (active[id]) begin
                t = cyc - acc[id] + 1;
                if (t < f)
                    check({cs, rdy} == 2'b00, "cs_ready_busy", {cs, rdy}, 0);
                else
                    check({cs, dclk} == 2'b10, "cs_high_after_frame", {cs, dclk}, 2'b10);
                if (t > 1 && t < f && dat !== prev_data[id]) begin
                    if (nedge[id] > 0)
                        check(t - last_rise[id] >= d, "hold_time", t - last_rise[id], d);
                    last_chg[id] = t;
                end
                if (dclk && !prev_clk[id]) begin
                    check(t == 1 + d + 2 * nedge[id] * d, "rise_time", t, 1 + d + 2 * nedge[id] * d);
                    check(t - last_chg[id] >= d, "setup_time", t - last_chg[id], d);
                    cap[id] = {cap[id][W-2:0], dat};
                    nedge[id]++;
                    last_rise[id] = t;
                end
                if (dn) begin
                    check(t == f + gap - 1, "done_time", t, f + gap - 1);
                    done_seen[id] = 1'b1;
                end
                if (t == f) begin
                    check(dat == 1'b0, "data_zero_at_cs_rise", dat, 0);
                    check(nedge[id] == W, "rise_count", nedge[id], W);
                    pop_exp(id, exp_w, ok);
                    check(ok && cap[id] == exp_w, "captured_word", cap[id], exp_w);
                end
                if (t == f + gap) begin
                    check(rdy && done_seen[id], "ready_and_done", {rdy, done_seen[id]}, 2'b11);
                    active[id] = 1'b0;
                end
            end else begin
                check({cs, dclk, dn, rdy} == 4'b1001, "idle_outputs", {cs, dclk, dn, rdy}, 4'b1001);
            end
        end
        prev_clk[id]   = dclk;
        prev_data[id]  = dat;
        prev_ready[id] = rdy;
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, D0, G0, 1'b0, rst0, if0.iVALID, if0.oDAC_CS, if0.oDAC_CLK,
            if0.oDAC_DATA, if0.oREADY, if0.oDONE);
    end

    always @(posedge clk) begin
        #1;
        mon(1, D1, G1, 1'b1, rst1, if1.iVALID, if1.oDAC_CS, if1.oDAC_CLK,
            if1.oDAC_DATA, if1.oREADY, if1.oDONE);
    end

    task automatic send0(input logic [W-1:0] w, input bit keep, output int a);
        a = -1;
        if0.iDATA  = w;
        if0.iVALID = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (if0.oREADY && !rst0) begin
                q0.push_back(w);
                a = cyc + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check(a >= 0, "accept_wait0", a, 0);
        if (!keep) if0.iVALID = 1'b0;
    endtask

    task automatic send1(input logic [W-1:0] w, input bit keep, output int a);
        a = -1;
        if1.iDATA  = w;
        if1.iVALID = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (if1.oREADY && !rst1) begin
                q1.push_back(w);
                a = cyc + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check(a >= 0, "accept_wait1", a, 0);
        if (!keep) if1.iVALID = 1'b0;
    endtask

    task automatic wait_idle0();
        for (int n = 0; n < 400 && !if0.oREADY; n++) @(negedge clk);
        check(if0.oREADY == 1'b1, "idle_wait0", if0.oREADY, 1);
    endtask

    task automatic run_dut0();
        int           a;
        int           a2;
        logic [W-1:0] words[4];
        words = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};

        send0(16'hA5C3, 1'b0, a);
        wait_idle0();

        for (int i = 0; i < 4; i++) begin
            send0(words[i], 1'b0, a);
            wait_idle0();
        end

        send0(16'h1234, 1'b1, a);
        send0(16'hFEDC, 1'b0, a2);
        check(a2 - a == 1 + (2 * W + 2) * D0 + G0, "b2b_accept_spacing", a2 - a,
              1 + (2 * W + 2) * D0 + G0);
        wait_idle0();

        // A request raised mid-frame must be dropped, not queued.
        send0(16'h0F0F, 1'b0, a);
        while (cyc < a + 49) @(negedge clk);
        if0.iDATA  = 16'hDEAD;
        if0.iVALID = 1'b1;
        @(negedge clk);
        if0.iVALID = 1'b0;
        wait_idle0();
        repeat (20) @(negedge clk);
        check(q0.size() == 0, "busy_request_ignored", q0.size(), 0);

        send0(16'h3C3C, 1'b0, a);
        while (cyc < a + 59) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        send0(16'h5555, 1'b0, a);
        wait_idle0();

        rst0       = 1'b1;
        if0.iDATA  = 16'hBEEF;
        if0.iVALID = 1'b1;
        @(negedge clk);
        rst0       = 1'b0;
        if0.iVALID = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_dut1();
        int a;
        for (int i = 0; i < 200; i++) send1(16'($urandom), i != 199, a);
        for (int n = 0; n < 100 && !if1.oREADY; n++) @(negedge clk);
        check(if1.oREADY == 1'b1, "idle_wait1", if1.oREADY, 1);
    endtask

    initial begin
        rst0       = 1'b1;
        rst1       = 1'b1;
        if0.iVALID = 1'b0;
        if0.iDATA  = '0;
        if1.iVALID = 1'b0;
        if1.iDATA  = '0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        fork
            run_dut0();
            run_dut1();
        join
        repeat (5) @(negedge clk);
        check(q0.size() == 0, "queue0_drained", q0.size(), 0);
        check(q1.size() == 0, "queue1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
